// File: rtl/mcu_multi_cycle.sv
// Multi-cycle core for the 16-bit MCU ISA; instruction and data memories sit behind req/ack ports.
// Optional macro MCU_STEP_EN: a fetch starts only when run and step are both high.
module mcu_multi_cycle #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned IADDR_W = 8,
    parameter int unsigned DADDR_W = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               run,
    input  logic               step,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]   dmem_wdata,
    input  logic               dmem_ack,
    input  logic [WIDTH-1:0]   dmem_rdata,
    output logic [IADDR_W-1:0] pc,
    output logic [15:0]        instr,
    output logic               halted,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [WIDTH-1:0]   dbg_data
);
    localparam int unsigned NREGS = 1 << REG_AW;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t             r_state;
    logic [IADDR_W-1:0] r_pc;
    logic [15:0]        r_instr;
    logic [WIDTH-1:0]   r_a, r_b, r_alu, r_mdr;
    logic [WIDTH-1:0]   r_regs [NREGS];
    logic               r_ipend, r_clr_q, r_halted;
    logic               r_dreq, r_dwe;
    logic [DADDR_W-1:0] r_daddr;
    logic [WIDTH-1:0]   r_dwdata;

    logic [3:0]         w_op;
    logic [REG_AW-1:0]  w_rs, w_rt, w_rd, w_dst;
    logic [WIDTH-1:0]   w_simm, w_alu;
    logic [IADDR_W-1:0] w_br, w_jmp;
    logic               w_start, w_is_nop;

`ifdef MCU_STEP_EN
    assign w_start = run & step;
`else
    logic w_unused;
    assign w_unused = step;
    assign w_start  = run;
`endif

    assign w_op     = r_instr[15:12];
    assign w_rs     = REG_AW'(r_instr[11:8]);
    assign w_rt     = REG_AW'(r_instr[7:4]);
    assign w_rd     = REG_AW'(r_instr[3:0]);
    assign w_dst    = (w_op == OP_ADDI || w_op == OP_LW) ? w_rt : w_rd;
    assign w_simm   = WIDTH'($signed(r_instr[3:0]));
    assign w_br     = r_pc + IADDR_W'($signed(r_instr[3:0]));
    assign w_jmp    = IADDR_W'(r_instr[11:0]);
    assign w_is_nop = (w_op >= 4'hA) && (w_op <= 4'hE);

    always_comb begin
        w_alu = r_a + r_b;
        case (w_op)
            OP_SUB:                w_alu = r_a - r_b;
            OP_AND:                w_alu = r_a & r_b;
            OP_OR:                 w_alu = r_a | r_b;
            OP_SLT:                w_alu = ($signed(r_a) < $signed(r_b)) ? WIDTH'(1) : '0;
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + w_simm;
            default:               w_alu = r_a + r_b;
        endcase
    end

    // Fetch request is decoded from state so a zero-wait fetch completes in the FETCH cycle;
    // r_ipend keeps it up once issued even if run drops, r_clr_q keeps it low right after clear.
    assign imem_req   = (r_state == S_FETCH) && !clear && !r_clr_q && (r_ipend || w_start);
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dreq;
    assign dmem_we    = r_dwe;
    assign dmem_addr  = r_daddr;
    assign dmem_wdata = r_dwdata;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign halted     = r_halted;
    assign dbg_data   = r_regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_instr  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_alu    <= '0;
            r_mdr    <= '0;
            r_regs   <= '{default: '0};
            r_ipend  <= 1'b0;
            r_clr_q  <= 1'b1;
            r_halted <= 1'b0;
            r_dreq   <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_dwdata <= '0;
        end else begin
            r_clr_q <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            r_instr <= imem_data;
                            r_pc    <= r_pc + IADDR_W'(1);
                            r_ipend <= 1'b0;
                            r_state <= S_DECODE;
                        end else begin
                            r_ipend <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_is_nop) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    case (w_op)
                        OP_BNE: begin
                            if (r_a != r_b) r_pc <= w_br;
                            r_state <= S_FETCH;
                        end
                        OP_J: begin
                            r_pc    <= w_jmp;
                            r_state <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            r_dreq   <= 1'b1;
                            r_dwe    <= (w_op == OP_SW);
                            r_daddr  <= DADDR_W'(w_alu);
                            r_dwdata <= r_b;
                            r_state  <= S_MEM;
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (r_dreq && dmem_ack) begin
                        r_dreq <= 1'b0;
                        r_dwe  <= 1'b0;
                        if (w_op == OP_SW) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_regs[w_dst] <= (w_op == OP_LW) ? r_mdr : r_alu;
                    r_state       <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule
